ib_lut_update_ctrl: RTL and testbench

- Sequences iteration-update writes into the shared IB-VNU LUT RAM pair (replicate 0/1) that serves the 3-bit VNU F0 stage.
- Writes are ping-pong double-buffered: a new LUT image goes into the frame half not currently being read.
- At the decoder's next iteration boundary the block flips `read_addr_offset`, so readers switch to the new image atomically.
- Sits between the LUT-image source (stream, valid/ready) and the RAM write ports / read-offset input of the VNU datapath.

---
 rtl/ib_lut_update_ctrl_if.sv | 64 ++++++
 rtl/ib_lut_update_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ib_lut_update_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ib_lut_update_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ib_lut_update_ctrl_if
// Description : Bundle of the LUT-image stream, the RAM write ports and the
//               read-frame control of the IB-VNU LUT update controller.
//               master : the controller (drives RAM writes, lut_ready, status)
//               slave  : the environment (LUT source, decoder, RAM side)
//               Optional expected_chksum exists when IB_UPDATE_CHKSUM_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface ib_lut_update_ctrl_if #(
  parameter int ENTRY_ADDR = 5,
  parameter int DATA_W     = 3
);
  // control pulses from the decoder / host
  logic                  update_start;
  logic                  update_abort;
  logic                  iter_boundary;
  // LUT image stream
  logic                  lut_valid;
  logic                  lut_ready;
  logic [DATA_W-1:0]     lut_data_0;
  logic [DATA_W-1:0]     lut_data_1;
  // RAM write ports (replicate 0/1)
  logic [ENTRY_ADDR-1:0] page_addr_ram_replicate_0;
  logic [ENTRY_ADDR-1:0] page_addr_ram_replicate_1;
  logic [DATA_W-1:0]     ram_write_data_0;
  logic [DATA_W-1:0]     ram_write_data_1;
  logic                  ib_ram_we;
  // read-frame select and status
  logic                  read_addr_offset;
  logic                  busy;
  logic                  update_done;
  logic                  update_err;
`ifdef IB_UPDATE_CHKSUM_EN
  logic [DATA_W-1:0]     expected_chksum;
`endif

  modport master (
`ifdef IB_UPDATE_CHKSUM_EN
    input  expected_chksum,
`endif
    input  update_start, update_abort, iter_boundary,
    input  lut_valid, lut_data_0, lut_data_1,
    output lut_ready,
    output page_addr_ram_replicate_0, page_addr_ram_replicate_1,
    output ram_write_data_0, ram_write_data_1, ib_ram_we,
    output read_addr_offset, busy, update_done, update_err
  );

  modport slave (
`ifdef IB_UPDATE_CHKSUM_EN
    output expected_chksum,
`endif
    output update_start, update_abort, iter_boundary,
    output lut_valid, lut_data_0, lut_data_1,
    input  lut_ready,
    input  page_addr_ram_replicate_0, page_addr_ram_replicate_1,
    input  ram_write_data_0, ram_write_data_1, ib_ram_we,
    input  read_addr_offset, busy, update_done, update_err
  );
endinterface
`default_nettype wire

// File: rtl/ib_lut_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ib_lut_update_ctrl
// Description : Ping-pong LUT image update sequencer for the IB-VNU LUT RAM
//               pair. A new image is written page by page into the frame half
//               not currently read; at the next decoder iteration boundary the
//               read frame offset flips so readers switch atomically.
// Ports       : write_clk - sole clock
//               rst       - synchronous active-high reset
//               bus       - ib_lut_update_ctrl_if.master (stream in, RAM write
//                           ports, read_addr_offset, busy/done/err status)
// Option      : IB_UPDATE_CHKSUM_EN - adds expected_chksum; the XOR of all
//               accepted lut_data_0 beats must match it or the swap is
//               cancelled with update_err.
// Revision    : 1.0 - initial release
// ============================================================================
module ib_lut_update_ctrl #(
  parameter int QUAN_SIZE       = 3,
  parameter int ENTRY_ADDR      = $clog2(2**((QUAN_SIZE*2)-1)),
  parameter int MULTI_FRAME_NUM = 2,
  parameter int BANK_NUM        = 1,
  parameter int LUT_PORT_SIZE   = 3,
  parameter int PAGE_NUM        = 2**(ENTRY_ADDR-1)
) (
  input  logic                  write_clk,
  input  logic                  rst,
  ib_lut_update_ctrl_if.master  bus
);

  localparam int c_data_w = LUT_PORT_SIZE*BANK_NUM;
  localparam int c_cnt_w  = ENTRY_ADDR-MULTI_FRAME_NUM+1;
  localparam logic [c_cnt_w-1:0] c_last_page = c_cnt_w'(PAGE_NUM-1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_SWAP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_wr_off;   // frozen write half for the whole update
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_ready;
  logic                  r_we;
  logic [ENTRY_ADDR-1:0] r_addr;
  logic [c_data_w-1:0]   r_data_0;
  logic [c_data_w-1:0]   r_data_1;
  logic                  r_rd_off;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_beat;
  assign w_beat = bus.lut_valid & r_ready;

`ifdef IB_UPDATE_CHKSUM_EN
  logic [c_data_w-1:0]   r_chk;
  logic [c_data_w-1:0]   r_exp_chk;
  logic [c_data_w-1:0]   w_chk_next;
  // Includes the current beat so the last beat can be judged in the same
  // cycle it is accepted.
  assign w_chk_next = r_chk ^ bus.lut_data_0;
`endif

  always_ff @(posedge write_clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wr_off  <= 1'b0;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data_0  <= '0;
      r_data_1  <= '0;
      r_rd_off  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef IB_UPDATE_CHKSUM_EN
      r_chk     <= '0;
      r_exp_chk <= '0;
`endif
    end else begin
      // single-cycle strobes
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // abort in the same cycle cancels the start
          if (bus.update_start && !bus.update_abort) begin
            r_state  <= S_LOAD;
            r_wr_off <= ~r_rd_off;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b1;
`ifdef IB_UPDATE_CHKSUM_EN
            r_chk     <= '0;
            r_exp_chk <= bus.expected_chksum;
`endif
          end
        end
        S_LOAD: begin
          if (bus.update_start) r_err <= 1'b1;
          if (bus.update_abort) begin
            // abort wins over a same-cycle beat: nothing is written
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_beat) begin
            r_we     <= 1'b1;
            r_addr   <= {r_wr_off, r_cnt};
            r_data_0 <= bus.lut_data_0;
            r_data_1 <= bus.lut_data_1;
            r_cnt    <= r_cnt + 1'b1;
`ifdef IB_UPDATE_CHKSUM_EN
            r_chk    <= w_chk_next;
`endif
            if (r_cnt == c_last_page) begin
              r_ready <= 1'b0;
`ifdef IB_UPDATE_CHKSUM_EN
              if (w_chk_next != r_exp_chk) begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_WAIT_SWAP;
              end
`else
              r_state <= S_WAIT_SWAP;
`endif
            end
          end
        end
        S_WAIT_SWAP: begin
          if (bus.update_start) r_err <= 1'b1;
          if (bus.update_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.iter_boundary) begin
            r_rd_off <= ~r_rd_off;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lut_ready                 = r_ready;
  assign bus.ib_ram_we                 = r_we;
  assign bus.page_addr_ram_replicate_0 = r_addr;
  assign bus.page_addr_ram_replicate_1 = r_addr;
  assign bus.ram_write_data_0          = r_data_0;
  assign bus.ram_write_data_1          = r_data_1;
  assign bus.read_addr_offset          = r_rd_off;
  assign bus.busy                      = r_busy;
  assign bus.update_done               = r_done;
  assign bus.update_err                = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ib_lut_update_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ib_lut_update_ctrl
// Description : Self-checking bench for ib_lut_update_ctrl. A transaction
//               level reference model (queue of pending write addresses,
//               active read half, running checksum) predicts every output
//               each cycle. Define IB_UPDATE_CHKSUM_EN to also exercise the
//               checksum option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ib_lut_update_ctrl;

  localparam int PAGES = 16;

  logic write_clk = 1'b0;
  logic rst       = 1'b1;

  ib_lut_update_ctrl_if #(.ENTRY_ADDR(5), .DATA_W(3)) bus ();

  ib_lut_update_ctrl dut (
    .write_clk (write_clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 write_clk = ~write_clk;

  // ---------------- reference model state ----------------
  bit         m_active = 1'b0;   // an update is in progress
  int         m_q[$];            // addresses still to be written
  bit         m_off    = 1'b0;   // active read half
  logic [2:0] m_chk    = '0;
  logic [2:0] m_exp    = '0;
  logic       e_ready = 0, e_we = 0, e_busy = 0, e_done = 0, e_err = 0;
  logic [4:0] e_addr  = '0;
  logic [2:0] e_d0 = '0, e_d1 = '0;

  logic [2:0] img0 [PAGES];
  logic [2:0] img1 [PAGES];
  logic [2:0] tb_exp = '0;
  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [2:0] img_xor();
    logic [2:0] x = '0;
    for (int i = 0; i < PAGES; i++) x ^= img0[i];
    return x;
  endfunction

  function automatic int beats();
    return m_active ? PAGES - m_q.size() : 0;
  endfunction

  function automatic bit loading();
    return m_active && (m_q.size() != 0);
  endfunction

  function automatic logic [21:0] dut_vec();
    return {bus.lut_ready, bus.ib_ram_we, bus.page_addr_ram_replicate_0,
            bus.page_addr_ram_replicate_1, bus.ram_write_data_0,
            bus.ram_write_data_1, bus.read_addr_offset, bus.busy,
            bus.update_done, bus.update_err};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {e_ready, e_we, e_addr, e_addr, e_d0, e_d1, m_off, e_busy,
            e_done, e_err};
  endfunction

  // Predicts the outputs after one clock edge from the inputs applied to it.
  task automatic model_step();
    if (rst) begin
      m_active = 0; m_q.delete(); m_off = 0; m_chk = '0; m_exp = '0;
      e_ready = 0; e_we = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_addr = '0; e_d0 = '0; e_d1 = '0;
    end else begin
      e_we = 0; e_done = 0; e_err = 0;
      if (!m_active) begin
        if (bus.update_start && !bus.update_abort) begin
          m_active = 1;
          m_q.delete();
          for (int i = 0; i < PAGES; i++) m_q.push_back((m_off ? 0 : 16) + i);
          e_ready = 1; e_busy = 1; m_chk = '0; m_exp = tb_exp;
        end
      end else begin
        if (bus.update_start) e_err = 1;
        if (bus.update_abort) begin
          m_active = 0; m_q.delete(); e_ready = 0; e_busy = 0;
        end else if (m_q.size() != 0) begin
          if (bus.lut_valid) begin
            e_we = 1; e_addr = 5'(m_q.pop_front());
            e_d0 = bus.lut_data_0; e_d1 = bus.lut_data_1;
            m_chk ^= bus.lut_data_0;
            if (m_q.size() == 0) begin
              e_ready = 0;
`ifdef IB_UPDATE_CHKSUM_EN
              if (m_chk != m_exp) begin e_err = 1; m_active = 0; e_busy = 0; end
`endif
            end
          end
        end else if (bus.iter_boundary) begin
          m_off = !m_off; e_done = 1; m_active = 0; e_busy = 0;
        end
      end
    end
  endtask

  // Applies one cycle of inputs, advances the clock and the model.
  task automatic cyc(input bit st, input bit ab, input bit ib, input bit v,
                     input logic [2:0] d0, input logic [2:0] d1, input bit r);
    rst = r;
    bus.update_start = st; bus.update_abort = ab; bus.iter_boundary = ib;
    bus.lut_valid = v; bus.lut_data_0 = d0; bus.lut_data_1 = d1;
`ifdef IB_UPDATE_CHKSUM_EN
    bus.expected_chksum = tb_exp;
`endif
    @(posedge write_clk);
    model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 3'($urandom), 3'($urandom), 1);
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (dut_vec() !== 22'd0) begin n_fail++; $display("FAIL reset_release got=%h exp=0", dut_vec()); end
  endtask

  task automatic test_update(input bit exp_off, input string nm);
    int nwe = 0;
    for (int i = 0; i < PAGES; i++) begin img0[i] = 3'(i); img1[i] = 3'(15 - i); end
    tb_exp = img_xor();
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL %s_start got=%h exp=%h", nm, dut_vec(), exp_vec()); end
    for (int i = 0; i < PAGES; i++) begin
      cyc(0, 0, 0, 1, img0[i], img1[i], 0);
      if (bus.ib_ram_we === 1'b1) nwe++;
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL %s_beat%0d got=%h exp=%h", nm, i, dut_vec(), exp_vec()); end
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, (i == 4), 0, 0, 0, 0);
      if (bus.ib_ram_we === 1'b1) nwe++;
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL %s_swap%0d got=%h exp=%h", nm, i, dut_vec(), exp_vec()); end
    end
    n_chk++; if (nwe !== PAGES) begin n_fail++; $display("FAIL %s_wecount got=%0d exp=%0d", nm, nwe, PAGES); end
    n_chk++; if (bus.read_addr_offset !== exp_off) begin n_fail++; $display("FAIL %s_offset got=%b exp=%b", nm, bus.read_addr_offset, exp_off); end
  endtask

  task automatic test_random_gaps();
    int nwe = 0;
    int guard = 0;
    bit v;
    for (int i = 0; i < PAGES; i++) begin img0[i] = 3'($urandom); img1[i] = 3'($urandom); end
    tb_exp = img_xor();
    cyc(1, 0, 0, 0, 0, 0, 0);
    while (loading() && guard < 300) begin
      v = ($urandom_range(0, 2) == 0);
      if (v) cyc(0, 0, 0, 1, img0[beats()], img1[beats()], 0);
      else   cyc(0, 0, 0, 0, 3'($urandom), 3'($urandom), 0);
      if (bus.ib_ram_we === 1'b1) nwe++;
      guard++;
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL gaps_cyc%0d got=%h exp=%h", guard, dut_vec(), exp_vec()); end
    end
    n_chk++; if (guard >= 300) begin n_fail++; $display("FAIL gaps_bound got=%0d exp=<300", guard); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, (i == 2), 0, 0, 0, 0);
      if (bus.ib_ram_we === 1'b1) nwe++;
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL gaps_swap%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
    n_chk++; if (nwe !== PAGES) begin n_fail++; $display("FAIL gaps_wecount got=%0d exp=%0d", nwe, PAGES); end
  endtask

  task automatic test_boundary_ignore();
    int ndone = 0;
    int guard = 0;
    bit v, ib;
    for (int i = 0; i < PAGES; i++) begin img0[i] = 3'($urandom); img1[i] = 3'($urandom); end
    tb_exp = img_xor();
    cyc(1, 0, 1, 0, 0, 0, 0);
    while (loading() && guard < 300) begin
      v  = ($urandom_range(0, 1) == 0);
      ib = ($urandom_range(0, 3) == 0) || (v && m_q.size() == 1);
      cyc(0, 0, ib, v, v ? img0[beats()] : 3'd0, v ? img1[beats()] : 3'd0, 0);
      if (bus.update_done === 1'b1) ndone++;
      guard++;
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL bnd_cyc%0d got=%h exp=%h", guard, dut_vec(), exp_vec()); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, (i == 2), 0, 0, 0, 0);
      if (bus.update_done === 1'b1) ndone++;
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL bnd_wait%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
    n_chk++; if (ndone !== 1) begin n_fail++; $display("FAIL bnd_donecount got=%0d exp=1", ndone); end
  endtask

  task automatic test_start_busy();
    int nerr = 0;
    for (int i = 0; i < PAGES; i++) begin img0[i] = 3'($urandom); img1[i] = 3'($urandom); end
    tb_exp = img_xor();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < PAGES; i++) begin
      cyc((i == 7), 0, 0, 1, img0[i], img1[i], 0);
      if (bus.update_err === 1'b1) nerr++;
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL busy_beat%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
    for (int i = 0; i < 3; i++) begin
      cyc((i == 0), 0, (i == 1), 0, 0, 0, 0);
      if (bus.update_err === 1'b1) nerr++;
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL busy_wait%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
    n_chk++; if (nerr !== 2) begin n_fail++; $display("FAIL busy_errcount got=%0d exp=2", nerr); end
  endtask

  task automatic test_abort();
    int ndone = 0;
    bit off0;
    off0 = m_off;
    for (int i = 0; i < PAGES; i++) begin img0[i] = 3'($urandom); img1[i] = 3'($urandom); end
    tb_exp = img_xor();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 9; i++) begin
      cyc(0, (i == 9), 0, 1, img0[i], img1[i], 0);
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL abort_beat%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
    // idle abort, start+abort together, idle boundary: all no-ops
    for (int i = 0; i < 5; i++) begin
      cyc((i == 2), (i == 0 || i == 2), (i == 3), 1, 3'($urandom), 3'($urandom), 0);
      if (bus.update_done === 1'b1) ndone++;
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL abort_idle%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
    n_chk++; if (bus.read_addr_offset !== off0 || ndone !== 0) begin n_fail++; $display("FAIL abort_nosswap got=%b/%0d exp=%b/0", bus.read_addr_offset, ndone, off0); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < PAGES; i++) begin img0[i] = 3'($urandom); img1[i] = 3'($urandom); end
    tb_exp = img_xor();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, img0[i], img1[i], 0);
    cyc(0, 0, 0, 1, img0[4], img1[4], 1);
    n_chk++; if (dut_vec() !== 22'd0) begin n_fail++; $display("FAIL rstmid got=%h exp=0", dut_vec()); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL rstmid_after got=%h exp=%h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_back_to_back();
    int guard;
    bit v;
    for (int u = 0; u < 4; u++) begin
      for (int i = 0; i < PAGES; i++) begin img0[i] = 3'($urandom); img1[i] = 3'($urandom); end
      tb_exp = img_xor();
      cyc(1, 0, 0, 0, 0, 0, 0);
      guard = 0;
      while (m_active && guard < 200) begin
        v = ($urandom_range(0, 3) != 0);
        cyc(0, 0, !loading(), v, img0[beats() % PAGES], img1[beats() % PAGES], 0);
        guard++;
        n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL b2b_u%0d_c%0d got=%h exp=%h", u, guard, dut_vec(), exp_vec()); end
      end
      n_chk++; if (guard >= 200) begin n_fail++; $display("FAIL b2b_bound u=%0d got=%0d exp=<200", u, guard); end
    end
  endtask

`ifdef IB_UPDATE_CHKSUM_EN
  task automatic test_chksum();
    bit off0;
    int nerr = 0;
    for (int pass = 0; pass < 2; pass++) begin
      off0 = m_off;
      for (int i = 0; i < PAGES; i++) begin
        img0[i] = (pass == 0) ? 3'($urandom) : 3'(i);
        img1[i] = 3'($urandom);
      end
      tb_exp = (pass == 0) ? img_xor() : 3'h5;
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < PAGES + 4; i++) begin
        cyc(0, 0, (i == PAGES + 1), (i < PAGES), img0[i % PAGES], img1[i % PAGES], 0);
        if (pass == 1 && bus.update_err === 1'b1) nerr++;
        n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL chk_p%0d_c%0d got=%h exp=%h", pass, i, dut_vec(), exp_vec()); end
      end
      n_chk++; if (bus.read_addr_offset !== (pass == 0 ? !off0 : off0)) begin n_fail++; $display("FAIL chk_p%0d_offset got=%b exp=%b", pass, bus.read_addr_offset, (pass == 0 ? !off0 : off0)); end
    end
    n_chk++; if (nerr !== 1) begin n_fail++; $display("FAIL chk_errcount got=%0d exp=1", nerr); end
  endtask
`endif

  initial begin
    test_reset();
    test_update(1'b1, "first");
    test_update(1'b0, "second");
    test_random_gaps();
    test_boundary_ignore();
    test_start_busy();
    test_abort();
    test_rst_mid();
    test_back_to_back();
`ifdef IB_UPDATE_CHKSUM_EN
    test_chksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
